icache_controller: RTL and testbench

Direct-mapped instruction cache controller sitting between the CPU's PC/fetch port and the 128-bit-block instruction memory. It is the initiator side of the instruction-memory read/busywait handshake. Hits return a 32-bit instruction in the same cycle. Misses stall the CPU, fetch a 16-byte block, refill the line and then replay as a hit.

---
 rtl/icache_controller.sv | 109 ++++++++++
 tb/tb_icache_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped instruction cache, 8 lines x 16 bytes.
// Hits answer combinationally; misses stall, refill the line, then replay.
module icache_controller #(
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readinstruction,
  input  logic         mem_busywait
);

  localparam int BLK_W = BLOCK_BYTES * 8;
  localparam int IDX_W = $clog2(NUM_LINES);

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [NUM_LINES-1:0] valid;
  logic [2:0]           tags [NUM_LINES];
  logic [BLK_W-1:0]     data [NUM_LINES];

  logic [2:0]       tag_in;
  logic [IDX_W-1:0] idx;
  logic [1:0]       offset;
  logic             hit;
  logic [BLK_W-1:0] line;
  logic [31:0]      word;
  logic             addr_unused;

  assign tag_in      = address[9:7];
  assign idx         = address[6:4];
  assign offset      = address[3:2];
  assign addr_unused = ^address[1:0];

  assign line = data[idx];
  assign hit  = valid[idx] && (tags[idx] == tag_in);

  // pick the addressed word out of the indexed line
  always_comb begin
    word = line[31:0];
    unique case (offset)
      2'b00: word = line[31:0];
      2'b01: word = line[63:32];
      2'b10: word = line[95:64];
      2'b11: word = line[127:96];
      default: word = line[31:0];
    endcase
  end

  assign instruction = hit ? word : 32'h0;
  assign busywait    = (read && !hit) || (state != IDLE);

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and memory request; address held by the CPU during a miss
  always_comb begin
    state_nx    = state;
    mem_read    = 1'b0;
    mem_address = 6'h0;
    unique case (state)
      IDLE: begin
        if (read && !hit && !mem_busywait) state_nx = MEM_READ;
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = {tag_in, idx};
        if (!mem_busywait) state_nx = UPDATE;
      end
      UPDATE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // valid bits: cleared by reset, set when a line is refilled
  always_ff @(posedge clock) begin
    if (reset)                valid      <= '0;
    else if (state == UPDATE) valid[idx] <= 1'b1;
  end

  // tag and data arrays: written only on refill, never reset
  always_ff @(posedge clock) begin
    if (!reset && state == UPDATE) begin
      tags[idx] <= tag_in;
      data[idx] <= mem_readinstruction;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: directed plus randomized checks of the icache
// against a cache-contents model and a latency-programmable memory stub.
module tb_icache_controller;

  logic         clock;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinstruction = '0;
  logic         mem_busywait;

  int total = 0;
  int bad   = 0;

  icache_controller dut (
    .clock              (clock),
    .reset              (reset),
    .read               (read),
    .address            (address),
    .instruction        (instruction),
    .busywait           (busywait),
    .mem_read           (mem_read),
    .mem_address        (mem_address),
    .mem_readinstruction(mem_readinstruction),
    .mem_busywait       (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory image and stub: busy for lat sampled edges per request
  logic [127:0] blk [64];
  int           lat_fixed = 2;
  int           lat = 0;
  int           wait_cnt = 0;
  logic         ext_busy = 1'b0;

  assign mem_busywait = ext_busy || (mem_read && (wait_cnt < lat));

  always @(posedge clock) begin
    if (mem_read) begin
      if (wait_cnt < lat) wait_cnt <= wait_cnt + 1;
      mem_readinstruction <= blk[mem_address];
    end else begin
      wait_cnt <= 0;
      lat <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] b,
                                          input logic [1:0] o);
    return b[32*o +: 32];
  endfunction

  // reference model: cache contents plus outstanding request / refill
  logic [7:0]   mv = '0;
  logic [2:0]   mt [8];
  logic [127:0] md [8];
  logic         m_req = 1'b0;
  logic         m_upd = 1'b0;
  int           stall = 0;
  int           nb = 0;
  logic         mr_prev = 1'b0;
  logic [5:0]   fetch_q [$];

  always @(negedge clock) begin
    logic [2:0] ix;
    logic [2:0] tg;
    logic [1:0] of;
    logic       hm;
    logic       act;
    ix  = address[6:4];
    tg  = address[9:7];
    of  = address[3:2];
    hm  = mv[ix] && (mt[ix] == tg);
    act = m_req || m_upd;
    chk("busywait", 128'(busywait), 128'((read && !hm) || act));
    chk("mem_read", 128'(mem_read), 128'(m_req));
    if (m_req) chk("mem_address", 128'(mem_address), 128'({tg, ix}));
    if (read && hm && !act)
      chk("instruction", 128'(instruction), 128'(word_of(md[ix], of)));
    if (mem_read && !mr_prev) fetch_q.push_back(mem_address);
    mr_prev = mem_read;
    if (reset) begin
      stall = 0;
      nb    = 0;
    end else if (busywait) begin
      stall++;
      if (mem_busywait && (m_req || !act)) nb++;
    end else if (stall != 0) begin
      chk("stall_len", 128'(stall), 128'(nb + 3));
      stall = 0;
      nb    = 0;
    end
    if (reset) begin
      mv    = '0;
      m_req = 1'b0;
      m_upd = 1'b0;
    end else if (m_upd) begin
      md[ix] = blk[{tg, ix}];
      mt[ix] = tg;
      mv[ix] = 1'b1;
      m_upd  = 1'b0;
    end else if (m_req) begin
      if (!mem_busywait) begin
        m_req = 1'b0;
        m_upd = 1'b1;
      end
    end else if (read && !hm && !mem_busywait) begin
      m_req = 1'b1;
    end
  end

  task automatic access(input logic [9:0] a, output int n);
    @(posedge clock);
    #1;
    read    = 1'b1;
    address = a;
    n = 0;
    @(negedge clock);
    while (busywait && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (busywait) chk("access_timeout", 128'(busywait), 128'(0));
  endtask

  task automatic do_reset;
    @(posedge clock);
    #1;
    reset = 1'b1;
    read  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] w0 [4];
  int          n;
  int          k;
  logic        lb;

  initial begin
    w0[0] = 32'h44332211;
    w0[1] = 32'h88776655;
    w0[2] = 32'hCCBBAA99;
    w0[3] = 32'h00FFEEDD;
    for (int i = 0; i < 64; i++)
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
    blk[0]  = {w0[3], w0[2], w0[1], w0[0]};
    blk[63] = {32'hCAFEF00D, 32'h3, 32'h2, 32'h1};

    reset   = 1'b1;
    read    = 1'b0;
    address = 10'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busywait", 128'(busywait), 128'(0));
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_address", 128'(mem_address), 128'(0));
    chk("rst_instruction", 128'(instruction), 128'(0));

    // first miss, then hits on the rest of the block
    fetch_q.delete();
    access(10'h000, n);
    chk("miss_stall", 128'(n), 128'(5));
    chk("miss_instr", 128'(instruction), 128'(32'h44332211));
    chk("miss_fetches", 128'(fetch_q.size()), 128'(1));
    for (int i = 1; i < 4; i++) begin
      access(10'(i * 4), n);
      chk("hit_stall", 128'(n), 128'(0));
      chk("hit_instr", 128'(instruction), 128'(w0[i]));
    end
    chk("hit_fetches", 128'(fetch_q.size()), 128'(1));

    // conflict eviction on index 0
    do_reset();
    fetch_q.delete();
    access(10'h000, n);
    access(10'h080, n);
    access(10'h000, n);
    chk("conflict_cnt", 128'(fetch_q.size()), 128'(3));
    if (fetch_q.size() == 3) begin
      chk("conflict_a0", 128'(fetch_q[0]), 128'(6'h00));
      chk("conflict_a1", 128'(fetch_q[1]), 128'(6'h08));
      chk("conflict_a2", 128'(fetch_q[2]), 128'(6'h00));
    end

    // long memory latency
    lat_fixed = 10;
    access(10'h100, n);
    chk("long_stall", 128'(n), 128'(13));

    // reset in the third MEM_READ cycle, memory still busy afterwards
    fetch_q.delete();
    @(posedge clock);
    #1;
    read    = 1'b1;
    address = 10'h000;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!mem_read && k < 20);
    chk("rm_req_seen", 128'(mem_read), 128'(1));
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset    = 1'b1;
    ext_busy = 1'b1;
    @(negedge clock);
    chk("rm_before", 128'(mem_read), 128'(1));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rm_after", 128'(mem_read), 128'(0));
    chk("rm_busy", 128'(busywait), 128'(1));
    repeat (4) begin
      @(negedge clock);
      chk("rm_wait", 128'(mem_read), 128'(0));
    end
    @(posedge clock);
    #1 ext_busy = 1'b0;
    k = 0;
    @(negedge clock);
    while (busywait && k < 200) begin
      k++;
      @(negedge clock);
    end
    chk("rm_done", 128'(busywait), 128'(0));
    chk("rm_instr", 128'(instruction), 128'(32'h44332211));
    chk("rm_fetches", 128'(fetch_q.size()), 128'(2));

    // no read: no stall, no fetch
    @(posedge clock);
    #1;
    read    = 1'b0;
    address = 10'($urandom);
    repeat (20) begin
      @(negedge clock);
      chk("idle_busy", 128'(busywait), 128'(0));
      chk("idle_mem_read", 128'(mem_read), 128'(0));
    end

    // last word, zero-latency memory
    lat_fixed = 0;
    fetch_q.delete();
    access(10'h3FC, n);
    chk("top_stall", 128'(n), 128'(3));
    chk("top_instr", 128'(instruction), 128'(32'hCAFEF00D));
    if (fetch_q.size() > 0)
      chk("top_addr", 128'(fetch_q[$]), 128'(6'h3F));
    else
      chk("top_fetch", 128'(fetch_q.size()), 128'(1));

    // randomized traffic with random latency and occasional reset
    lat_fixed = -1;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clock);
      lb = busywait;
      @(posedge clock);
      #1;
      reset = ($urandom_range(0, 99) == 0);
      if (!lb) begin
        read    = ($urandom_range(0, 4) != 0);
        address = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      end
    end
    #1 reset = 1'b0;
    read = 1'b0;
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
